// File: rtl/scan_auth_response_checker_pkg.sv
// rtl/scan_auth_response_checker_pkg.sv - shared security package: FSM encoding and MISR constants
package scan_auth_response_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_t;

    localparam logic [15:0] SAR_MISR_POLY = 16'h1021;
    localparam logic [15:0] SAR_MISR_SEED = 16'hFFFF;

    // A zero threshold would make tamper fire on the very first compare; treat it as 1.
    function automatic logic [3:0] eff_fail_limit(input logic [3:0] lim);
        return (lim == 4'd0) ? 4'd1 : lim;
    endfunction

endpackage

// File: rtl/scan_auth_response_checker_misr.sv
// rtl/scan_auth_response_checker_misr.sv - serial-input MISR compactor for scan-out responses
module misr_compactor #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (shift_en) begin
            sig <= {sig[SIG_W-2:0], din} ^ (sig[SIG_W-1] ? POLY : '0);
        end
    end

endmodule

// File: rtl/scan_auth_response_checker.sv
// rtl/scan_auth_response_checker.sv - compacts one scan unload and checks it against a golden signature
module scan_auth_response_checker
    import scan_auth_response_checker_pkg::*;
#(
    parameter int               SIG_W     = 16,
    parameter int               CNT_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = SAR_MISR_POLY,
    parameter logic [SIG_W-1:0] MISR_SEED = SAR_MISR_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_auth,
    input  logic [CNT_W-1:0] l_scan,
    input  logic             scan_bit,
    input  logic             scan_valid,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic [3:0]       fail_limit,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig,
    output logic             match,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             tamper
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sar_state_t       state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] l_scan_q;
    logic             is_auth_q;
    logic             start_ok;
    logic             clear_ok;
    logic             shift_en;
    logic             last_bit;
    logic             sig_eq;
    logic [CNT_W-1:0] pass_cnt_nxt;
    logic [CNT_W-1:0] fail_cnt_nxt;
    logic             tamper_hit;

    assign start_ok = (state == ST_IDLE) && start;
    assign clear_ok = (state == ST_IDLE) && !start && clear;
    assign shift_en = (state == ST_SHIFT) && scan_valid;
    assign last_bit = shift_en && ((bit_cnt + CNT_ONE) == l_scan_q);
    assign sig_eq   = (sig == expected_sig);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    misr_compactor #(
        .SIG_W (SIG_W),
        .POLY  (MISR_POLY),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_ok),
        .shift_en (shift_en),
        .din      (scan_bit),
        .sig      (sig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = (l_scan == '0) ? ST_COMPARE : ST_SHIFT;
            ST_SHIFT:   if (last_bit) state_nxt = ST_COMPARE;
            ST_COMPARE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Counter outcome of the current compare; both counters stick at all-ones.
    always_comb begin
        pass_cnt_nxt = pass_cnt;
        fail_cnt_nxt = fail_cnt;
        if (is_auth_q) begin
            if (sig_eq) begin
                if (pass_cnt != '1) pass_cnt_nxt = pass_cnt + CNT_ONE;
            end else begin
                if (fail_cnt != '1) fail_cnt_nxt = fail_cnt + CNT_ONE;
            end
        end
    end

    assign tamper_hit = (fail_cnt_nxt >= CNT_W'(eff_fail_limit(fail_limit)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            l_scan_q  <= '0;
            is_auth_q <= 1'b0;
            match     <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            tamper    <= 1'b0;
        end else begin
            if (start_ok) begin
                bit_cnt   <= '0;
                l_scan_q  <= l_scan;
                is_auth_q <= is_auth;
            end else if (clear_ok) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
                tamper   <= 1'b0;
                match    <= 1'b0;
            end
            if (shift_en) begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
            if (state == ST_COMPARE) begin
                match    <= is_auth_q && sig_eq;
                pass_cnt <= pass_cnt_nxt;
                fail_cnt <= fail_cnt_nxt;
                if (tamper_hit) tamper <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_auth_response_checker.sv
// tb/tb_scan_auth_response_checker.sv - self-checking bench for scan_auth_response_checker
module tb_scan_auth_response_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_auth;
    logic [15:0] l_scan;
    logic        scan_bit;
    logic        scan_valid;
    logic [15:0] expected_sig;
    logic [3:0]  fail_limit;
    logic        clear;
    logic        busy;
    logic        done;
    logic [15:0] sig;
    logic        match;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic        tamper;

    int n_vec = 0;
    int n_err = 0;
    int m_pass = 0;
    int m_fail = 0;
    bit m_match = 1'b0;
    bit m_tamper = 1'b0;

    always #5 clk = ~clk;

    scan_auth_response_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_auth      (is_auth),
        .l_scan       (l_scan),
        .scan_bit     (scan_bit),
        .scan_valid   (scan_valid),
        .expected_sig (expected_sig),
        .fail_limit   (fail_limit),
        .clear        (clear),
        .busy         (busy),
        .done         (done),
        .sig          (sig),
        .match        (match),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .tamper       (tamper)
    );

    // Signature as the remainder of the seeded bit stream modulo x^16+x^12+x^5+1.
    function automatic logic [15:0] ref_sig(input logic [63:0] bits, input int len);
        logic [16:0] acc;
        acc = 17'h0FFFF;
        for (int i = 0; i < len; i++) begin
            acc = {acc[15:0], bits[i]};
            if (acc[16]) acc = acc ^ 17'h11021;
        end
        return acc[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_compare(input bit auth, input logic [15:0] s, input logic [15:0] e);
        int lim;
        lim = (fail_limit == 4'd0) ? 1 : int'(fail_limit);
        if (auth) begin
            m_match = (s == e);
            if (m_match) begin
                if (m_pass < 65535) m_pass++;
            end else begin
                if (m_fail < 65535) m_fail++;
            end
        end else begin
            m_match = 1'b0;
        end
        if (m_fail >= lim) m_tamper = 1'b1;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_match"},  match,    32'(m_match));
        check({tag, "_pass"},   pass_cnt, 32'(m_pass));
        check({tag, "_fail"},   fail_cnt, 32'(m_fail));
        check({tag, "_tamper"}, tamper,   32'(m_tamper));
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        m_pass = 0; m_fail = 0; m_tamper = 1'b0; m_match = 1'b0;
        check_results(tag);
    endtask

    task automatic run_pattern(input string tag, input bit auth, input int len,
                               input logic [63:0] bits, input logic [15:0] exp,
                               input bit gaps, input bit poke, input bit clr_with_start);
        logic [15:0] r;
        int g;
        r = ref_sig(bits, len);
        @(negedge clk);
        start = 1'b1; is_auth = auth; l_scan = len[15:0]; expected_sig = exp; clear = clr_with_start;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            start = 1'b0; clear = 1'b0;
            if (gaps) begin
                g = $urandom_range(2, poke ? 1 : 0);
                repeat (g) begin
                    scan_valid = 1'b0; scan_bit = 1'($urandom);
                    if (poke) begin start = 1'b1; clear = 1'b1; end
                    @(negedge clk);
                    start = 1'b0; clear = 1'b0;
                end
            end
            scan_valid = 1'b1; scan_bit = bits[i];
        end
        @(negedge clk);
        start = 1'b0; clear = 1'b0; scan_valid = 1'b0; scan_bit = 1'($urandom);
        check({tag, "_cmp_done"}, done, 0);
        check({tag, "_cmp_busy"}, busy, 1);
        @(negedge clk);
        model_compare(auth, r, exp);
        check({tag, "_done"}, done, 1);
        check({tag, "_sig"},  sig,  32'(r));
        check_results(tag);
        @(negedge clk);
        check({tag, "_post_done"}, done, 0);
        check({tag, "_post_busy"}, busy, 0);
        check({tag, "_hold_sig"},  sig,  32'(r));
        check({tag, "_hold_match"}, match, 32'(m_match));
    endtask

    initial begin
        logic [63:0] bits;
        logic [15:0] r;
        int len;
        rst_n = 1'b0; start = 1'b0; is_auth = 1'b0; l_scan = '0; scan_bit = 1'b0;
        scan_valid = 1'b0; expected_sig = '0; fail_limit = 4'd15; clear = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sig",  sig,  32'hFFFF);
        check_results("rst");
        rst_n = 1'b1;

        // Zero-length unload compares the seed directly
        run_pattern("len0", 1'b1, 0, 64'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check("len0_pass_lit", pass_cnt, 1);

        // Single-bit unloads
        run_pattern("one0", 1'b1, 1, 64'h0, 16'hEFDF, 1'b0, 1'b0, 1'b0);
        check("one0_sig_lit", sig, 32'hEFDF);
        run_pattern("one1", 1'b1, 1, 64'h1, 16'hEFDF, 1'b0, 1'b0, 1'b0);
        check("one1_sig_lit", sig, 32'hEFDE);
        check("one1_fail_lit", fail_cnt, 1);

        // Tamper threshold of 2
        do_clear("clr0");
        fail_limit = 4'd2;
        for (int k = 0; k < 2; k++) begin
            len = $urandom_range(16, 1);
            bits = {$urandom, $urandom};
            r = ref_sig(bits, len);
            run_pattern("tfail", 1'b1, len, bits, r ^ 16'h0001, 1'b0, 1'b0, 1'b0);
            check("tfail_tamper_lit", tamper, (k == 1) ? 1 : 0);
        end
        do_clear("clr1");
        check("clr1_tamper_lit", tamper, 0);

        // Dummy pattern with a wrong signature leaves the counters alone
        fail_limit = 4'd15;
        run_pattern("pre_dummy", 1'b1, 5, 64'h15, ref_sig(64'h15, 5), 1'b0, 1'b0, 1'b0);
        run_pattern("dummy", 1'b0, 12, 64'hABC, ref_sig(64'hABC, 12) ^ 16'h8000, 1'b0, 1'b0, 1'b0);

        // start and clear pulsed during SHIFT with gapped data, then start+clear together in IDLE
        bits = {$urandom, $urandom};
        run_pattern("poke8", 1'b1, 8, bits, 16'h1234, 1'b1, 1'b1, 1'b0);
        run_pattern("stclr", 1'b1, 3, 64'h5, ref_sig(64'h5, 3), 1'b0, 1'b0, 1'b1);

        // Randomized patterns against the reference model
        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(20, 0);
            bits = {$urandom, $urandom};
            r = ref_sig(bits, len);
            fail_limit = 4'($urandom_range(6, 0));
            if ($urandom_range(4, 0) == 0) do_clear("rclr");
            run_pattern("rand", 1'($urandom), len, bits,
                        ($urandom_range(1, 0) == 1) ? r : 16'($urandom),
                        1'($urandom), 1'b0, 1'b0);
        end

        // Reset after 3 of 8 bits aborts the unload
        @(negedge clk);
        start = 1'b1; is_auth = 1'b1; l_scan = 16'd8; expected_sig = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0; scan_valid = 1'b1; scan_bit = 1'($urandom);
        end
        @(negedge clk);
        scan_valid = 1'b0;
        check("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        m_pass = 0; m_fail = 0; m_match = 1'b0; m_tamper = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sig",  sig,  32'hFFFF);
        check_results("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
